// File: rtl/io_resp.sv
// I/O responder: bridges decoder INN/OUT requests to per-port valid/ready streams; optional IO_TIMEOUT_EN bounds waits.
// Latency: io_in valid one cycle after the read is served; ext_out_data/valid one cycle after the write is accepted.
// Backpressure: stall held while the selected read buffer is empty or the selected write register is still occupied.
module io_resp #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4,
  parameter int NBIOAD = 2,
  parameter int TMOUT  = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_in,
  input  logic [NBIOAD-1:0]         addr_in,
  output logic [NUBITS-1:0]         io_in,
  input  logic                      out_en,
  input  logic [NBIOAD-1:0]         addr_out,
  input  logic [NUBITS-1:0]         io_out,
  output logic                      stall,
  input  logic [NUIOIN*NUBITS-1:0]  ext_in_data,
  input  logic [NUIOIN-1:0]         ext_in_valid,
  output logic [NUIOIN-1:0]         ext_in_ready,
  output logic [NUIOOU*NUBITS-1:0]  ext_out_data,
  output logic [NUIOOU-1:0]         ext_out_valid,
  input  logic [NUIOOU-1:0]         ext_out_ready,
  output logic                      io_err
);

  localparam int IW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int OW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
  localparam logic [NBIOAD:0] IN_LIM  = (NBIOAD+1)'(NUIOIN);
  localparam logic [NBIOAD:0] OUT_LIM = (NBIOAD+1)'(NUIOOU);

  if (TMOUT < 1) begin : gBadTmout
    $error("io_resp: TMOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, IN_WAIT, OUT_WAIT} stateT;

  stateT             state, nextState;
  logic [NUBITS-1:0] bufQ [NUIOIN];
  logic [NUIOIN-1:0] bufV, inTake, rdClr;
  logic [NUIOOU-1:0] outV, wrSel;
  logic [IW-1:0]     inIdx, latIn, rdIdx;
  logic [OW-1:0]     outIdx, latOut, wrIdx;
  logic [NUBITS-1:0] latDat, wrDat;
  logic inOk, outOk, rdFire, rdZero, wrFire, setErr, latchIn, latchOut, waitReq, timeout;

  assign inIdx  = addr_in[IW-1:0];
  assign outIdx = addr_out[OW-1:0];
  assign inOk   = {1'b0, addr_in} < IN_LIM;
  assign outOk  = {1'b0, addr_out} < OUT_LIM;

  assign ext_in_ready  = ~bufV;
  assign ext_out_valid = outV;
  assign inTake        = ext_in_valid & ~bufV;
  assign rdClr         = rdFire ? (NUIOIN'(1) << rdIdx) : '0;
  assign wrSel         = wrFire ? (NUIOOU'(1) << wrIdx) : '0;
  // Reset must release the pipeline at once, even while the decoder still holds its request.
  assign stall         = waitReq & rst;

`ifdef IO_TIMEOUT_EN
  localparam int CW = $clog2(TMOUT + 1);
  logic [CW-1:0] waitCnt;

  assign timeout = (waitCnt == CW'(TMOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) waitCnt <= '0;
    else      waitCnt <= (nextState != IDLE) ? waitCnt + CW'(1) : '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    nextState = state;
    waitReq   = 1'b0;
    rdFire    = 1'b0;
    rdZero    = 1'b0;
    rdIdx     = inIdx;
    wrFire    = 1'b0;
    wrIdx     = outIdx;
    wrDat     = io_out;
    setErr    = 1'b0;
    latchIn   = 1'b0;
    latchOut  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_in) begin
          setErr = out_en;
          if (!inOk) begin
            rdZero = 1'b1;
            setErr = 1'b1;
          end else if (bufV[inIdx]) begin
            rdFire = 1'b1;
          end else begin
            waitReq   = 1'b1;
            latchIn   = 1'b1;
            nextState = IN_WAIT;
          end
        end else if (out_en) begin
          if (!outOk) begin
            setErr = 1'b1;
          end else if (!outV[outIdx] || ext_out_ready[outIdx]) begin
            wrFire = 1'b1;
          end else begin
            waitReq   = 1'b1;
            latchOut  = 1'b1;
            nextState = OUT_WAIT;
          end
        end
      end
      IN_WAIT: begin
        rdIdx = latIn;
        if (bufV[latIn]) begin
          rdFire    = 1'b1;
          nextState = IDLE;
        end else if (timeout) begin
          rdZero    = 1'b1;
          setErr    = 1'b1;
          nextState = IDLE;
        end else begin
          waitReq = 1'b1;
        end
      end
      OUT_WAIT: begin
        wrIdx = latOut;
        wrDat = latDat;
        if (ext_out_ready[latOut]) begin
          wrFire    = 1'b1;
          nextState = IDLE;
        end else if (timeout) begin
          setErr    = 1'b1;
          nextState = IDLE;
        end else begin
          waitReq = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      io_in        <= '0;
      io_err       <= 1'b0;
      bufV         <= '0;
      outV         <= '0;
      ext_out_data <= '0;
      latIn        <= '0;
      latOut       <= '0;
      latDat       <= '0;
      for (int i = 0; i < NUIOIN; i++) bufQ[i] <= '0;
    end else begin
      state  <= nextState;
      io_err <= io_err | setErr;
      if (rdFire)      io_in <= bufQ[rdIdx];
      else if (rdZero) io_in <= '0;
      if (latchIn)  latIn <= inIdx;
      if (latchOut) begin
        latOut <= outIdx;
        latDat <= io_out;
      end
      // A read clears a full slot whose ready was low, so refill can only start next cycle.
      bufV <= (bufV & ~rdClr) | inTake;
      for (int i = 0; i < NUIOIN; i++)
        if (inTake[i]) bufQ[i] <= ext_in_data[i*NUBITS +: NUBITS];
      outV <= (outV & ~ext_out_ready) | wrSel;
      for (int i = 0; i < NUIOOU; i++)
        if (wrSel[i]) ext_out_data[i*NUBITS +: NUBITS] <= wrDat;
    end
  end

endmodule

// File: tb/tb_io_resp.sv
// Directed bench for io_resp with 3-bit addresses so out-of-range ports are reachable.
module tb_io_resp;

  localparam int NUBITS = 32;
  localparam int NUIOIN = 4;
  localparam int NUIOOU = 4;
  localparam int NBIOAD = 3;
  localparam int TMOUT  = 8;

  logic                     clk, rst;
  logic                     req_in, out_en, stall, io_err;
  logic [NBIOAD-1:0]        addr_in, addr_out;
  logic [NUBITS-1:0]        io_in, io_out;
  logic [NUIOIN*NUBITS-1:0] ext_in_data;
  logic [NUIOIN-1:0]        ext_in_valid, ext_in_ready;
  logic [NUIOOU*NUBITS-1:0] ext_out_data;
  logic [NUIOOU-1:0]        ext_out_valid, ext_out_ready;

  int nChecks = 0;
  int nErrors = 0;

  io_resp #(
    .NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .NBIOAD(NBIOAD), .TMOUT(TMOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .out_en(out_en), .addr_out(addr_out), .io_out(io_out),
    .stall(stall),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .io_err(io_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; req_in = 1'b0; addr_in = '0; out_en = 1'b0; addr_out = '0; io_out = '0;
    ext_in_data = '0; ext_in_valid = '0; ext_out_ready = '0;
    tick(); tick();
    chk("rst_io_in",     io_in, 32'h0);
    chk("rst_stall",     32'(stall), 32'h0);
    chk("rst_in_ready",  32'(ext_in_ready), 32'hF);
    chk("rst_out_valid", 32'(ext_out_valid), 32'h0);
    chk("rst_out_data0", ext_out_data[31:0], 32'h0);
    chk("rst_err",       32'(io_err), 32'h0);
    rst = 1'b1;
    tick();

    // Preloaded read on port 1
    ext_in_data[63:32] = 32'hA5; ext_in_valid = 4'b0010;
    #1 chk("pre_rdy_empty", 32'(ext_in_ready[1]), 32'h1);
    tick(); ext_in_valid = '0;
    #1 chk("pre_rdy_full", 32'(ext_in_ready[1]), 32'h0);
    req_in = 1'b1; addr_in = 3'd1;
    #1 chk("pre_stall", 32'(stall), 32'h0);
    tick(); req_in = 1'b0;
    #1 chk("pre_io_in", io_in, 32'hA5);
    chk("pre_rdy_again", 32'(ext_in_ready[1]), 32'h1);

    // Empty read on port 2, data shows up in the fifth stalled cycle
    req_in = 1'b1; addr_in = 3'd2;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        ext_in_data[95:64] = 32'h1234; ext_in_valid = 4'b0100;
      end
      #1 chk($sformatf("empty_stall_%0d", k), 32'(stall), 32'h1);
      tick();
    end
    ext_in_valid = '0;
    #1 chk("empty_stall_drop", 32'(stall), 32'h0);
    chk("empty_io_in_hold", io_in, 32'hA5);
    tick(); req_in = 1'b0;
    #1 chk("empty_io_in", io_in, 32'h1234);
    chk("empty_idle", 32'(stall), 32'h0);

    // Write backpressure on port 0
    out_en = 1'b1; addr_out = 3'd0; io_out = 32'h11;
    #1 chk("wr1_stall", 32'(stall), 32'h0);
    tick(); io_out = 32'h22;
    #1 chk("wr1_valid", 32'(ext_out_valid[0]), 32'h1);
    chk("wr1_data", ext_out_data[31:0], 32'h11);
    chk("wr2_stall", 32'(stall), 32'h1);
    tick();
    #1 chk("wr2_wait_stall", 32'(stall), 32'h1);
    chk("wr2_wait_data", ext_out_data[31:0], 32'h11);
    tick(); ext_out_ready = 4'b0001;
    #1 chk("wr2_release", 32'(stall), 32'h0);
    tick(); out_en = 1'b0; ext_out_ready = '0;
    #1 chk("wr2_data", ext_out_data[31:0], 32'h22);
    chk("wr2_valid", 32'(ext_out_valid[0]), 32'h1);
    ext_out_ready = 4'b0001;
    tick(); ext_out_ready = '0;
    #1 chk("wr_drain", 32'(ext_out_valid), 32'h0);

    // Simultaneous read and write: read wins, write dropped, error flagged
    chk("err_clear", 32'(io_err), 32'h0);
    ext_in_data[127:96] = 32'h3C; ext_in_valid = 4'b1000;
    tick(); ext_in_valid = '0;
    req_in = 1'b1; addr_in = 3'd3; out_en = 1'b1; addr_out = 3'd1; io_out = 32'h77;
    #1 chk("both_stall", 32'(stall), 32'h0);
    tick(); req_in = 1'b0; out_en = 1'b0;
    #1 chk("both_io_in", io_in, 32'h3C);
    chk("both_wr_dropped", 32'(ext_out_valid), 32'h0);
    chk("both_err", 32'(io_err), 32'h1);

    // Reset while waiting on empty port 0
    req_in = 1'b1; addr_in = 3'd0;
    tick();
    #1 chk("rstw_stall_before", 32'(stall), 32'h1);
    rst = 1'b0;
    #1 chk("rstw_stall", 32'(stall), 32'h0);
    chk("rstw_io_in", io_in, 32'h0);
    chk("rstw_in_ready", 32'(ext_in_ready), 32'hF);
    chk("rstw_err", 32'(io_err), 32'h0);
    req_in = 1'b0;
    tick(); rst = 1'b1;
    tick();
    out_en = 1'b1; addr_out = 3'd2; io_out = 32'h5;
    #1 chk("rstw_idle_stall", 32'(stall), 32'h0);
    tick(); out_en = 1'b0;
    #1 chk("rstw_idle_wr", 32'(ext_out_valid), 32'h4);

    // Out-of-range addresses
    ext_in_data[31:0] = 32'h5A; ext_in_valid = 4'b0001;
    tick(); ext_in_valid = '0; req_in = 1'b1; addr_in = 3'd0;
    tick(); req_in = 1'b0;
    #1 chk("oor_pre_io_in", io_in, 32'h5A);
    req_in = 1'b1; addr_in = 3'd5;
    #1 chk("oor_rd_stall", 32'(stall), 32'h0);
    tick(); req_in = 1'b0;
    #1 chk("oor_io_in", io_in, 32'h0);
    chk("oor_err", 32'(io_err), 32'h1);
    out_en = 1'b1; addr_out = 3'd6; io_out = 32'hEE;
    #1 chk("oor_wr_stall", 32'(stall), 32'h0);
    tick(); out_en = 1'b0;
    #1 chk("oor_wr_valid", 32'(ext_out_valid), 32'h4);

`ifdef IO_TIMEOUT_EN
    // Wait on empty port 1 is aborted after TMOUT stalled cycles
    rst = 1'b0;
    tick(); rst = 1'b1;
    ext_in_data[127:96] = 32'h99; ext_in_valid = 4'b1000;
    tick(); ext_in_valid = '0; req_in = 1'b1; addr_in = 3'd3;
    tick(); req_in = 1'b0;
    #1 chk("tmo_pre_io_in", io_in, 32'h99);
    chk("tmo_pre_err", 32'(io_err), 32'h0);
    req_in = 1'b1; addr_in = 3'd1;
    for (int k = 0; k < TMOUT; k++) begin
      #1 chk($sformatf("tmo_stall_%0d", k), 32'(stall), 32'h1);
      tick();
    end
    #1 chk("tmo_abort", 32'(stall), 32'h0);
    tick(); req_in = 1'b0;
    #1 chk("tmo_io_in", io_in, 32'h0);
    chk("tmo_err", 32'(io_err), 32'h1);
    chk("tmo_idle", 32'(stall), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/io_resp.md
Name: io_resp

Overview:
- Peripheral-side responder for the processor's I/O instructions.
- Serves INN/P_INN read requests (`req_in`) and OUT write requests (`out_en`) issued by the instruction decoder.
- Bridges them to per-port valid/ready streams toward external logic.
- Stalls the processor when a read port has no data or a write port is still occupied.

Parameters:
- NUBITS, 32, data word width.
- NUIOIN, 4, number of input ports.
- NUIOOU, 4, number of output ports.
- NBIOAD, 2, width of addr_in/addr_out.
- TMOUT, 1023, wait-cycle limit (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low.
- req_in  in  1  read request from decoder; held high while stall=1.
- addr_in  in  NBIOAD  read port select.
- io_in  out  NUBITS  read data to processor, registered.
- out_en  in  1  write request from decoder; held high while stall=1.
- addr_out  in  NBIOAD  write port select.
- io_out  in  NUBITS  write data from accumulator.
- stall  out  1  freezes processor pipeline, combinational.
- ext_in_data  in  NUIOIN*NUBITS  input port data; port i occupies bits [i*NUBITS +: NUBITS].
- ext_in_valid  in  NUIOIN  per-port valid.
- ext_in_ready  out  NUIOIN  per-port ready.
- ext_out_data  out  NUIOOU*NUBITS  output port data, registered.
- ext_out_valid  out  NUIOOU  per-port valid.
- ext_out_ready  in  NUIOOU  per-port ready.
- io_err  out  1  sticky error flag.

Behaviour:

Reset (rst=0, async): state=IDLE; io_in=0, buf_v=0, out_v=0, ext_out_data=0, io_err=0, wait counter=0.

Input side:
- One holding register buf[i] per port, flag buf_v[i].
- ext_in_ready[i] = ~buf_v[i]. Capture on valid&ready.
- A buffer cleared by a read may accept new data the following cycle (no same-cycle refill).

Output side:
- Register ext_out_data[i] with out_v[i]; ext_out_valid = out_v.
- Handshake completes on out_v & ext_out_ready; out_v clears next edge unless refilled the same cycle.

Read, state IDLE:
- req_in & buf_v[addr_in]: io_in <= buf[addr_in] and buf_v cleared at next edge; stall=0; io_in valid 1 cycle after request.
- req_in & ~buf_v[addr_in]: stall=1; latch addr; go IN_WAIT.

Read, state IN_WAIT:
- stall=1 until buf_v[lat_addr]=1.
- In that cycle: stall=0, capture into io_in, go IDLE. io_in is valid the next cycle, the same as the no-wait case.

Write, state IDLE:
- out_en & (~out_v[addr_out] | ext_out_ready[addr_out]): write io_out, set out_v, stall=0.
- Otherwise: stall=1; go OUT_WAIT.

Write, state OUT_WAIT:
- stall=1 until ext_out_ready[lat_addr]; in that cycle write, stall=0, go IDLE.

Boundary conditions:
- addr ≥ NUIOIN on read: io_in <= 0, no stall, io_err set.
- addr ≥ NUIOOU on write: write dropped, no stall, io_err set.
- req_in & out_en simultaneously (illegal): read served, write dropped, io_err set.
- New requests are ignored in wait states; the latched request completes.
- Reset mid-wait: returns to IDLE, stall=0; the pending transfer is lost.

Optional Feature:
Macro IO_TIMEOUT_EN.
- Defined:
  - A counter runs in IN_WAIT/OUT_WAIT and clears on entry to IDLE.
  - When it reaches TMOUT, the wait is aborted: stall=0 that cycle, go IDLE.
  - Aborted read: io_in <= 0. Aborted write: write dropped.
  - io_err set in both cases.
- Undefined: no counter; waits are unbounded; TMOUT is unused.

Test Plan:
- Preloaded read: ext_in port 1 = 0x0000_00A5 accepted, then req_in addr_in=1 -> stall stays 0, io_in=0xA5 next cycle, buf_v[1] cleared, ext_in_ready[1]=1 following cycle.
- Empty read: req_in addr_in=2, port 2 empty; data 0x1234 arrives 5 cycles later -> stall high 5 cycles; drops in capture cycle; io_in=0x1234 next cycle.
- Write backpressure: two out_en to port 0 (0x11 then 0x22) with ext_out_ready[0]=0 -> first write, no stall; second write stalls. Raise ready -> 0x11 consumed, 0x22 written same cycle, stall drops.
- Illegal/out-of-range: req_in & out_en same cycle -> read served, write dropped, io_err=1. Also addr_in=5 with NUIOIN=4 and NBIOAD=3 -> io_in=0, io_err=1.
- Reset during IN_WAIT: rst low for 1 cycle -> stall=0 immediately, all valids 0, io_in=0, state IDLE.
- IO_TIMEOUT_EN, TMOUT=8: read an empty port -> stall=1 for 8 cycles, then 0; io_in=0; io_err=1.
